// File: rtl/quotient_reconstructor.sv
// rtl/quotient_reconstructor.sv - shift-add rebuild of dividend as quotient*divisor+remainder
// Optional early exit on an exhausted multiplier: QRECON_EARLY_TERM_EN
module quotient_reconstructor #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic [WIDTH-1:0]     quotient,
  input  logic [WIDTH-1:0]     divisor,
  input  logic [WIDTH-1:0]     remainder,
  output logic [2*WIDTH-1:0]   product,
  output logic                 done,
  output logic                 error,
  output logic [3:0]           cs
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_LOAD  = 4'd1,
    S_CHECK = 4'd2,
    S_ADD   = 4'd3,
    S_SHIFT = 4'd4,
    S_DONE  = 4'd5,
    S_ERR   = 4'd6
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [PW-1:0]    md_q, md_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [PW-1:0]    product_q, product_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             last_pass;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      mq_q      <= '0;
      md_q      <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      rem_q     <= '0;
      div_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mq_q      <= mq_d;
      md_q      <= md_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      div_q     <= div_d;
      product_q <= product_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  // Outputs are computed from the next state so done rises on the very edge that enters DONE/ERR.
  always_comb begin
    state_d   = state_q;
    mq_d      = mq_q;
    md_d      = md_q;
    acc_d     = acc_q;
    count_d   = count_q;
    rem_d     = rem_q;
    div_d     = div_q;
    product_d = product_q;
    done_d    = done_q;
    error_d   = error_q;
    last_pass = 1'b0;

    case (state_q)
      S_IDLE: begin
        done_d  = 1'b0;
        error_d = 1'b0;
        if (go) state_d = S_LOAD;
      end
      S_LOAD: begin
        mq_d    = quotient;
        md_d    = {{WIDTH{1'b0}}, divisor};
        acc_d   = {{WIDTH{1'b0}}, remainder};
        rem_d   = remainder;
        div_d   = divisor;
        count_d = '0;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (md_q == '0 || rem_q >= div_q) begin
          state_d   = S_ERR;
          product_d = '0;
          done_d    = 1'b1;
          error_d   = 1'b1;
        end else begin
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        if (mq_q[0]) acc_d = acc_q + md_q;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        mq_d      = mq_q >> 1;
        md_d      = md_q << 1;
        count_d   = count_q + CW'(1);
        last_pass = (count_q == CW'(WIDTH - 1));
`ifdef QRECON_EARLY_TERM_EN
        if ((mq_q >> 1) == '0) last_pass = 1'b1;
`endif
        if (last_pass) begin
          state_d   = S_DONE;
          product_d = acc_q;
          done_d    = 1'b1;
          error_d   = 1'b0;
        end else begin
          state_d = S_ADD;
        end
      end
      S_DONE, S_ERR: begin
        if (!go) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
          error_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign product = product_q;
  assign done    = done_q;
  assign error   = error_q;
  assign cs      = state_q;

endmodule

// File: tb/tb_quotient_reconstructor.sv
// tb/tb_quotient_reconstructor.sv - directed and random round-trip checks of quotient_reconstructor
module tb_quotient_reconstructor;

  localparam int W = 4;

  logic           clk;
  logic           rst;
  logic           go;
  logic [W-1:0]   quotient;
  logic [W-1:0]   divisor;
  logic [W-1:0]   remainder;
  logic [2*W-1:0] product;
  logic           done;
  logic           error;
  logic [3:0]     cs;

  int vectors;
  int miscompares;

  quotient_reconstructor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .go        (go),
    .quotient  (quotient),
    .divisor   (divisor),
    .remainder (remainder),
    .product   (product),
    .done      (done),
    .error     (error),
    .cs        (cs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: arithmetic definition of the result and of the edge count to done.
  function automatic int ref_latency(input int q, input int d, input int r);
    int k;
    if (d == 0 || r >= d) return 3;
`ifdef QRECON_EARLY_TERM_EN
    k = 1;
    for (int b = 0; b < W; b++) if (((q >> b) & 1) == 1) k = b + 1;
`else
    k = W;
`endif
    return 2 * k + 3;
  endfunction

  task automatic run_op(input int q, input int d, input int r, input string tag);
    int  edges;
    int  exp_lat;
    bit  exp_err;
    int  exp_p;
    exp_err = (d == 0 || r >= d);
    exp_p   = exp_err ? 0 : q * d + r;
    exp_lat = ref_latency(q, d, r);
    @(negedge clk);
    quotient  = W'(q);
    divisor   = W'(d);
    remainder = W'(r);
    go        = 1'b1;
    edges     = 0;
    while (edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
      if (done) break;
    end
    check({tag, " latency"}, edges, exp_lat);
    check({tag, " done"}, done, 1);
    check({tag, " product"}, product, exp_p);
    check({tag, " error"}, error, exp_err);
    check({tag, " cs"}, cs, exp_err ? 6 : 5);
    // go still high: the block must hold, not restart
    @(posedge clk);
    #1;
    check({tag, " hold cs"}, cs, exp_err ? 6 : 5);
    check({tag, " hold product"}, product, exp_p);
    @(negedge clk);
    go = 1'b0;
    quotient  = W'($urandom);
    divisor   = W'($urandom);
    remainder = W'($urandom);
    @(posedge clk);
    #1;
    check({tag, " exit cs"}, cs, 0);
    check({tag, " exit done"}, done, 0);
    check({tag, " kept product"}, product, exp_p);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    go          = 1'b0;
    quotient    = '0;
    divisor     = '0;
    remainder   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset product", product, 0);
    check("reset done", done, 0);
    check("reset error", error, 0);
    check("reset cs", cs, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("idle cs", cs, 0);

    run_op(1, 3, 1, "basic");
    run_op(15, 15, 14, "max");

    // Reset asserted while in ADD after a held non-zero product
    @(negedge clk);
    quotient  = 4'd5;
    divisor   = 4'd3;
    remainder = 4'd2;
    go        = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midrun in ADD", cs, 3);
    rst = 1'b0;
    #1;
    check("midrun product", product, 0);
    check("midrun done", done, 0);
    check("midrun error", error, 0);
    check("midrun cs", cs, 0);
    @(negedge clk);
    go  = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post reset cs", cs, 0);
    check("post reset done", done, 0);

    run_op(3, 0, 0, "div0");
    run_op(2, 4, 4, "rem_eq_div");
    run_op(2, 4, 3, "rem_boundary");
    run_op(1, 7, 0, "early");
    run_op(0, 5, 4, "q_zero");
    run_op(8, 9, 0, "q_msb");

    for (int i = 0; i < 30; i++) begin
      int q, d, r;
      q = int'($urandom_range(0, 15));
      d = int'($urandom_range(0, 15));
      r = (i % 3 == 0) ? int'($urandom_range(0, 15)) : ((d == 0) ? 0 : int'($urandom_range(0, d - 1)));
      run_op(q, d, r, $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
